// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: active-low hex
// patterns {a,b,c,d,e,f,g}, the all-off pattern and the slot state type.
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0001100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = SEG_HEX_0;
      4'h1: o_seg = SEG_HEX_1;
      4'h2: o_seg = SEG_HEX_2;
      4'h3: o_seg = SEG_HEX_3;
      4'h4: o_seg = SEG_HEX_4;
      4'h5: o_seg = SEG_HEX_5;
      4'h6: o_seg = SEG_HEX_6;
      4'h7: o_seg = SEG_HEX_7;
      4'h8: o_seg = SEG_HEX_8;
      4'h9: o_seg = SEG_HEX_9;
      4'hA: o_seg = SEG_HEX_A;
      4'hB: o_seg = SEG_HEX_B;
      4'hC: o_seg = SEG_HEX_C;
      4'hD: o_seg = SEG_HEX_D;
      4'hE: o_seg = SEG_HEX_E;
      4'hF: o_seg = SEG_HEX_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with tear-free frame-boundary updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [4*DIGITS-1:0]   wr_data,
  output logic                  wr_ready,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  scan_state_e         r_state;
  logic [4*DIGITS-1:0] r_disp;
  logic [4*DIGITS-1:0] r_pend_data;
  logic                r_pend;

  logic                w_slot_end;
  logic                w_boundary;
  logic                w_accept;
  logic [3:0]          w_nib [DIGITS];
  logic [6:0]          w_seg_hex;
  logic                w_lz_blank;
  logic                w_on;

  assign w_slot_end = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_boundary = w_slot_end && (r_idx == IW'(DIGITS - 1));
  assign w_accept   = wr_valid && !r_pend;

  // State tracks the counter: DRIVE from count BLANK_CYC until the slot wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= ST_BLANK;
    end else if (w_slot_end) begin
      r_cnt   <= '0;
      r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      r_state <= ST_BLANK;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(BLANK_CYC - 1))
        r_state <= ST_DRIVE;
    end
  end

  // wr_ready is low while pending, so acceptance and commit never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_disp      <= '0;
    end else if (w_accept) begin
      r_pend      <= 1'b1;
      r_pend_data <= wr_data;
    end else if (w_boundary && r_pend) begin
      r_pend <= 1'b0;
      r_disp <= r_pend_data;
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign w_nib[gi] = r_disp[4*gi +: 4];
  end

  seg_hex_dec u_dec (
    .i_nib (w_nib[r_idx]),
    .o_seg (w_seg_hex)
  );

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] w_lz;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    if (gi == 0) begin : g_d0
      assign w_lz[gi] = 1'b0;
    end else begin : g_dn
      assign w_lz[gi] = ~|r_disp[4*DIGITS-1:4*gi];
    end
  end
  assign w_lz_blank = w_lz[r_idx];
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_on = (r_state == ST_DRIVE) && !w_lz_blank;

  always_comb begin
    an  = '1;
    seg = SEG_BLANK;
    if (w_on) begin
      an[r_idx] = 1'b0;
      seg       = w_seg_hex;
    end
  end

  assign wr_ready   = !r_pend;
  assign frame_done = w_boundary;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2):
// stimulus queues per-cycle expectations, a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0001100, SA = 7'b0001000, SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001, SD = 7'b1000010, SE = 7'b0110000, SF = 7'b0111000;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic        wr_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  typedef struct {
    int          cyc;
    bit          rst;
    logic [12:0] exp;
    string       tag;
  } exp_t;

  exp_t  q[$];
  int    cyc;
  int    n_chk = 0;
  int    n_err = 0;
  string phase = "init";

  // Cycle number since the last reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic push(input int c, input bit r, input logic [3:0] a, input logic [6:0] s,
                      input logic f, input logic rd);
    exp_t e;
    e.cyc = c; e.rst = r; e.exp = {a, s, f, rd};
    e.tag = $sformatf("%s@%0d", phase, c);
    q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t        e;
    logic [12:0] got;
    got = {an, seg, frame_done, wr_ready};
    while (q.size() > 0) begin
      e = q[0];
      if (e.rst == rst_n) break;
      if (e.cyc > cyc) break;
      void'(q.pop_front());
      n_chk++;
      if (e.cyc < cyc) begin
        n_err++;
        $display("FAIL %s not observed (now cycle %0d)", e.tag, cyc);
      end else if (got !== e.exp) begin
        n_err++;
        $display("FAIL %s got an=%b seg=%b fd=%b rdy=%b, want an=%b seg=%b fd=%b rdy=%b",
                 e.tag, got[12:9], got[8:2], got[1], got[0],
                 e.exp[12:9], e.exp[8:2], e.exp[1], e.exp[0]);
      end
    end
  end

  task automatic goto(input int n);
    while (cyc != n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wr_ready) break;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_data  = 16'($urandom);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout, %0d expectations pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, first frame of zeros, write 1234 committed at cycle 31.
    phase = "rst";
    push(0, 1, 4'hF, BL, 0, 1);
    phase = "f1";
    push(0, 0, 4'hF, BL, 0, 1);  push(1, 0, 4'hF, BL, 0, 1);
    push(2, 0, 4'hE, S0, 0, 1);  push(3, 0, 4'hE, S0, 0, 1);
    push(4, 0, 4'hE, S0, 0, 0);  push(7, 0, 4'hE, S0, 0, 0);
    push(8, 0, 4'hF, BL, 0, 0);  push(10, 0, 4'hD, S0, 0, 0);
    push(26, 0, 4'h7, S0, 0, 0); push(30, 0, 4'h7, S0, 0, 0);
    push(31, 0, 4'h7, S0, 1, 0); push(32, 0, 4'hF, BL, 0, 1);
    push(34, 0, 4'hE, S4, 0, 1); push(42, 0, 4'hD, S3, 0, 1);
    push(50, 0, 4'hB, S2, 0, 1); push(58, 0, 4'h7, S1, 0, 1);
    push(63, 0, 4'h7, S1, 1, 1);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    goto(3);
    wr(16'h1234);

    // Back-to-back: ABCD accepted, EF01 stalls until the next boundary.
    goto(64);
    phase = "b2b";
    push(64, 0, 4'hF, BL, 0, 1);  push(65, 0, 4'hF, BL, 0, 0);
    push(95, 0, 4'h7, S1, 1, 0);  push(96, 0, 4'hF, BL, 0, 1);
    push(97, 0, 4'hF, BL, 0, 0);  push(98, 0, 4'hE, SD, 0, 0);
    push(106, 0, 4'hD, SC, 0, 0); push(114, 0, 4'hB, SB, 0, 0);
    push(122, 0, 4'h7, SA, 0, 0); push(127, 0, 4'h7, SA, 1, 0);
    push(128, 0, 4'hF, BL, 0, 1); push(130, 0, 4'hE, S1, 0, 1);
    push(138, 0, 4'hD, S0, 0, 1); push(146, 0, 4'hB, SF, 0, 1);
    push(154, 0, 4'h7, SE, 0, 1);
    wr(16'hABCD);
    wr(16'hEF01);

    // Reset during digit 2 DRIVE with 5555 pending: pending data is lost.
    goto(160);
    phase = "rstmid";
    push(161, 0, 4'hF, BL, 0, 0); push(179, 0, 4'hB, SF, 0, 0);
    push(0, 1, 4'hF, BL, 0, 1);
    push(0, 0, 4'hF, BL, 0, 1);   push(2, 0, 4'hE, S0, 0, 1);
    push(10, 0, 4'hD, S0, 0, 1);  push(18, 0, 4'hB, S0, 0, 1);
    push(26, 0, 4'h7, S0, 0, 1);  push(31, 0, 4'h7, S0, 1, 1);
    push(34, 0, 4'hE, S0, 0, 1);
    wr(16'h5555);
    goto(180);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Leading zeros (0070, 0000), then the remaining hex patterns via 9865.
    goto(35);
    phase = "lz";
    push(36, 0, 4'hE, S0, 0, 0);  push(63, 0, 4'h7, S0, 1, 0);
    push(64, 0, 4'hF, BL, 0, 1);  push(65, 0, 4'hF, BL, 0, 0);
    push(66, 0, 4'hE, S0, 0, 0);  push(74, 0, 4'hD, S7, 0, 0);
    push(82, 0, LZB ? 4'hF : 4'hB, LZB ? BL : S0, 0, 0);
    push(90, 0, LZB ? 4'hF : 4'h7, LZB ? BL : S0, 0, 0);
    push(95, 0, LZB ? 4'hF : 4'h7, LZB ? BL : S0, 1, 0);
    push(96, 0, 4'hF, BL, 0, 1);  push(97, 0, 4'hF, BL, 0, 0);
    push(98, 0, 4'hE, S0, 0, 0);
    push(106, 0, LZB ? 4'hF : 4'hD, LZB ? BL : S0, 0, 0);
    push(114, 0, LZB ? 4'hF : 4'hB, LZB ? BL : S0, 0, 0);
    push(122, 0, LZB ? 4'hF : 4'h7, LZB ? BL : S0, 0, 0);
    push(127, 0, LZB ? 4'hF : 4'h7, LZB ? BL : S0, 1, 0);
    push(128, 0, 4'hF, BL, 0, 1); push(130, 0, 4'hE, S5, 0, 1);
    push(138, 0, 4'hD, S6, 0, 1); push(146, 0, 4'hB, S8, 0, 1);
    push(154, 0, 4'h7, S9, 0, 1);
    wr(16'h0070);
    goto(64);
    wr(16'h0000);
    goto(96);
    wr(16'h9865);

    for (int k = 0; k < 400 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed seven-segment digits (range 1-8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (must exceed BLANK_CYC).
REQ-003 SHALL have parameter BLANK_CYC, default 500, dead-time cycles at the start of each slot with all anodes off (range 1 to REFRESH_DIV-1).
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports as follows.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_valid  input  1  new display value offered.
REQ-008 wr_data  input  4*DIGITS  hex nibbles; digit i = wr_data[4i+3:4i].
REQ-009 wr_ready  output  1  block can accept wr_data this cycle.
REQ-010 an  output  DIGITS  active-low digit enables; an[i] low drives digit i.
REQ-011 seg  output  7  active-low segments {a,b,c,d,e,f,g}.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-013 Scan SHALL step digit index 0,1,...,DIGITS-1 and wrap to 0; each slot SHALL last exactly REFRESH_DIV cycles, counted by a slot counter 0..REFRESH_DIV-1.
REQ-014 FSM SHALL have two states: BLANK (slot count < BLANK_CYC) and DRIVE (slot count >= BLANK_CYC); BLANK->DRIVE at count BLANK_CYC, DRIVE->BLANK at count wrap with index increment.
REQ-015 In BLANK, an SHALL be all ones and seg SHALL be 7'b1111111.
REQ-016 In DRIVE, an SHALL be all ones except an[index]=0, and seg SHALL be the hex pattern of the displayed nibble: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-017 an and seg SHALL be decoded from registered state only (counter, index, display register); no input-to-output combinational path.
REQ-018 Handshake: a write is accepted on a rising edge where wr_valid and wr_ready are both 1; accepted data goes to a pending register and sets a pending flag.
REQ-019 wr_ready SHALL equal NOT pending flag; it SHALL fall the cycle after acceptance.
REQ-020 Frame boundary = the cycle the counter wraps while index is DIGITS-1; at that edge pending data SHALL copy into the display register and the pending flag SHALL clear (tear-free update).
REQ-021 Write and boundary in the same cycle is impossible because wr_ready is low while pending; a write accepted in the cycle after a boundary SHALL wait for the next boundary.
REQ-022 frame_done SHALL be 1 for exactly the boundary cycle, every frame, whether or not an update occurred.
REQ-023 wr_data while wr_valid=0 or wr_ready=0 SHALL be ignored.

Reset
REQ-024 While rst_n=0: counter=0, index=0, state BLANK, display register=0, pending flag=0, an=all ones, seg=7'b1111111, wr_ready=1, frame_done=0, asynchronously.
REQ-025 Reset mid-frame SHALL discard pending data; first slot after release SHALL be digit 0 beginning with BLANK.

Configuration
REQ-026 Macro SEG_SCAN_LZB_EN defined: leading-zero blanking; in DRIVE, digit i>0 SHALL keep an[i]=1 and seg=1111111 when nibbles i..DIGITS-1 of the display register are all zero; digit 0 is never blanked.
REQ-027 Macro SEG_SCAN_LZB_EN undefined: every digit SHALL be driven per REQ-016, including leading zeros.

Structure
REQ-028 Package seg_pkg SHALL hold the 16 hex segment constants, SEG_BLANK=7'b1111111, and the BLANK/DRIVE state typedef.
REQ-029 Sub-module seg_hex_dec (4-bit nibble to 7-bit active-low pattern, combinational) SHALL be instantiated once and shared across all digits via the index mux.

Verification (DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2)
REQ-030 Reset: rst_n low -> an=1111, seg=1111111, wr_ready=1; after release cycles 0-1 blank, cycles 2-7 an=1110 seg=0000001.
REQ-031 Write 16'h1234 at cycle 3 -> wr_ready=0 from cycle 4; digits show 0 until boundary cycle 31 (frame_done=1); next frame digit0 1001100, digit1 0000110, digit2 0010010, digit3 1001111; wr_ready=1 at cycle 32.
REQ-032 Back-to-back: 16'hABCD accepted, 16'hEF01 held valid -> stalls until wr_ready returns after boundary; frame 2 shows D,C,B,A, frame 3 shows 1,0,F,E.
REQ-033 With SEG_SCAN_LZB_EN, 16'h0070 -> an[3], an[2] stay 1, digit1 0001111, digit0 0000001; 16'h0000 -> only digit0 driven with 0000001; without macro all four digits driven.
REQ-034 rst_n pulsed low during digit 2 DRIVE with pending 16'h5555 -> an=1111 immediately; after release display stays 0000 and wr_ready=1.
